// File: rtl/baggage_pkg.sv
// Shared types and sizing for the sequenced baggage-drop controller.
package baggage_pkg;

  localparam int SENSOR_W  = 8;
  localparam int TIME_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ROOT_ITER = 12;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    ROOT,
    CMP,
    DONE
  } state_e;

  // Mean of four unsigned sensors: 10-bit sum, truncated divide by four.
  function automatic logic [SENSOR_W-1:0] avg4(
    input logic [SENSOR_W-1:0] a,
    input logic [SENSOR_W-1:0] b,
    input logic [SENSOR_W-1:0] c,
    input logic [SENSOR_W-1:0] d
  );
    logic [SENSOR_W+1:0] sum;
    sum  = (SENSOR_W+2)'(a) + (SENSOR_W+2)'(b) + (SENSOR_W+2)'(c) + (SENSOR_W+2)'(d);
    avg4 = SENSOR_W'(sum >> 2);
  endfunction

endpackage

// File: rtl/sqrt_iter.sv
// Restoring bit-serial square root: one root bit per step, MSB first, exact floor.
module sqrt_iter #(
  parameter int ITER = baggage_pkg::ROOT_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [2*ITER-1:0] radicand_i,
  output logic [ITER-1:0]   root_o,
  output logic              finished_o
);

  localparam int CW = $clog2(ITER + 1);

  logic [2*ITER-1:0] rad_q,  rad_d;
  logic [ITER+1:0]   rem_q,  rem_d;
  logic [ITER-1:0]   root_q, root_d;
  logic [CW-1:0]     cnt_q,  cnt_d;
  logic [ITER+3:0]   rem_t;
  logic [ITER+3:0]   trial;

  assign rem_t = {rem_q, rad_q[2*ITER-1 -: 2]};
  assign trial = (ITER+4)'({root_q, 2'b01});

  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      rad_d  = radicand_i;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
    end else if (step_i) begin
      rad_d = rad_q << 2;
      cnt_d = cnt_q + CW'(1);
      if (rem_t >= trial) begin
        rem_d  = (ITER+2)'(rem_t - trial);
        root_d = {root_q[ITER-2:0], 1'b1};
      end else begin
        rem_d  = (ITER+2)'(rem_t);
        root_d = {root_q[ITER-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
    end
  end

  // Flags the step that produces the final bit, so the caller can leave ROOT on that edge.
  assign finished_o = step_i && (cnt_q == CW'(ITER - 1));
  assign root_o     = root_q;

endmodule

// File: rtl/baggage_drop_ctrl.sv
// Sequenced baggage-drop controller: average sensors, serial sqrt fall time, limit compare.
module baggage_drop_ctrl #(
  parameter int FRAC_BITS = baggage_pkg::FRAC_BITS,
  parameter int ROOT_ITER = baggage_pkg::ROOT_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  sensor1,
  input  logic [7:0]  sensor2,
  input  logic [7:0]  sensor3,
  input  logic [7:0]  sensor4,
  input  logic [15:0] t_lim,
  input  logic        drop_en,
  output logic        busy,
  output logic        done,
  output logic [7:0]  height,
  output logic [15:0] t_act,
  output logic        drop_activated
);

  import baggage_pkg::*;

  localparam int RAD_W = SENSOR_W + 2*FRAC_BITS;

  state_e state_q, state_d;

  logic [3:0][SENSOR_W-1:0] sens_q;
  logic [TIME_W-1:0]        t_lim_q;
  logic                     drop_en_q;
  logic [SENSOR_W-1:0]      height_w_q;
  logic [SENSOR_W-1:0]      height_avg;
  logic [RAD_W-1:0]         radicand;
  logic [ROOT_ITER-1:0]     root;
  logic                     root_fin;
  logic                     sq_load, sq_step;
  logic [TIME_W-1:0]        t_w;
  logic                     drop_w;
  logic                     accept;

  logic [SENSOR_W-1:0]      height_q;
  logic [TIME_W-1:0]        t_act_q;
  logic                     drop_q;

  assign accept     = (state_q == IDLE) && start;
  assign height_avg = avg4(sens_q[0], sens_q[1], sens_q[2], sens_q[3]);
  assign radicand   = {height_avg, (2*FRAC_BITS)'(0)};
  assign t_w        = TIME_W'(root) >> 1;
  assign drop_w     = drop_en_q && (t_w <= t_lim_q);

  sqrt_iter #(.ITER(ROOT_ITER)) u_sqrt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sq_load),
    .step_i     (sq_step),
    .radicand_i (radicand),
    .root_o     (root),
    .finished_o (root_fin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SAMPLE;
      SAMPLE:  state_d = ROOT;
      ROOT:    if (root_fin) state_d = CMP;
      CMP:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    sq_load = (state_q == SAMPLE);
    sq_step = (state_q == ROOT);
  end

  // Results are committed on the edge into DONE so they are visible alongside the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sens_q     <= '0;
      t_lim_q    <= '0;
      drop_en_q  <= 1'b0;
      height_w_q <= '0;
      height_q   <= '0;
      t_act_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      if (accept) begin
        sens_q    <= {sensor4, sensor3, sensor2, sensor1};
        t_lim_q   <= t_lim;
        drop_en_q <= drop_en;
      end
      if (state_q == SAMPLE) height_w_q <= height_avg;
      if (state_q == CMP) begin
        height_q <= height_w_q;
        t_act_q  <= t_w;
        drop_q   <= drop_w;
      end
    end
  end

  assign height         = height_q;
  assign t_act          = t_act_q;
  assign drop_activated = drop_q;

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// Scoreboard bench for baggage_drop_ctrl: expected results queued at start, checked on done.
module tb_baggage_drop_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  sensor1, sensor2, sensor3, sensor4;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        busy, done, drop_activated;
  logic [7:0]  height;
  logic [15:0] t_act;

  typedef struct {
    logic [7:0]  h;
    logic [15:0] t;
    logic        d;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  baggage_drop_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .sensor1        (sensor1),
    .sensor2        (sensor2),
    .sensor3        (sensor3),
    .sensor4        (sensor4),
    .t_lim          (t_lim),
    .drop_en        (drop_en),
    .busy           (busy),
    .done           (done),
    .height         (height),
    .t_act          (t_act),
    .drop_activated (drop_activated)
  );

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int c, input int d,
                                 input int tl, input bit de);
    exp_t   e;
    longint rad, r;
    int     h;
    h   = (a + b + c + d) / 4;
    rad = longint'(h) * 65536;
    r   = 0;
    while ((r + 1) * (r + 1) <= rad) r++;
    e.h = 8'(h);
    e.t = 16'(r / 2);
    e.d = de && ((r / 2) <= tl);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("height", height, e.h);
        chk("t_act", t_act, e.t);
        chk("drop", drop_activated, e.d);
      end
    end
  end

  task automatic run(input int a, input int b, input int c, input int d,
                     input int tl, input bit de, input bit disturb, input string tag);
    int n;
    int d0;
    bit busy_all;
    sensor1 = 8'(a); sensor2 = 8'(b); sensor3 = 8'(c); sensor4 = 8'(d);
    t_lim = 16'(tl); drop_en = de; start = 1'b1;
    sb.push_back(model(a, b, c, d, tl, de));
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    busy_all = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!busy) busy_all = 1'b0;
      if (disturb && n == 3) begin
        start = 1'b1;
        sensor1 = ~sensor1; sensor2 = ~sensor2; sensor3 = ~sensor3; sensor4 = ~sensor4;
        t_lim = 16'd0; drop_en = ~drop_en;
      end
      if (disturb && n == 6) start = 1'b0;
      if (done) break;
    end
    chk({tag, "_latency"}, n, 15);
    chk({tag, "_busy"}, busy_all, 1);
    @(posedge clk); #1;
    repeat (3) @(negedge clk);
    chk({tag, "_ndone"}, done_cnt - d0, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int d0, n, first, second;
    rst = 1'b1; start = 1'b0; drop_en = 1'b0; t_lim = '0;
    sensor1 = '0; sensor2 = '0; sensor3 = '0; sensor4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_height", height, 0);
    chk("rst_t_act", t_act, 0);
    chk("rst_drop", drop_activated, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(100, 100, 100, 100, 1280, 1, 0, "h100_eq");
    chk("h100_t_const", t_act, 1280);
    run(100, 100, 100, 100, 1279, 1, 0, "h100_lt");

    // abort in ROOT: outputs must drop to reset values and no done may appear
    sensor1 = 8'd200; sensor2 = 8'd200; sensor3 = 8'd200; sensor4 = 8'd200;
    t_lim = 16'hFFFF; drop_en = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_height", height, 0);
    chk("abort_t_act", t_act, 0);
    chk("abort_drop", drop_activated, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_nodone", done_cnt - d0, 0);
    @(posedge clk); #1;

    run(10, 20, 30, 41, 16'hFFFF, 0, 0, "mix");
    chk("mix_t_const", t_act, 640);
    run(255, 255, 255, 255, 2043, 1, 0, "max_eq");
    chk("max_t_const", t_act, 2043);
    run(255, 255, 255, 255, 2042, 1, 0, "max_lt");
    run(0, 0, 0, 0, 0, 1, 0, "zero");
    chk("zero_t_const", t_act, 0);
    run(50, 60, 70, 80, 900, 1, 1, "disturb");
    repeat (4) run($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 2100), 1'($urandom), 0, "rand");

    // start held high re-triggers once IDLE is reached again
    sensor1 = 8'd30; sensor2 = 8'd40; sensor3 = 8'd50; sensor4 = 8'd60;
    t_lim = 16'd1000; drop_en = 1'b1; start = 1'b1;
    sb.push_back(model(30, 40, 50, 60, 1000, 1));
    sb.push_back(model(30, 40, 50, 60, 1000, 1));
    @(posedge clk); #1;
    n = 0; first = 0; second = 0;
    while (n < 60 && second == 0) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (first == 0) first = n;
        else begin
          second = n;
          start = 1'b0;
        end
      end
    end
    chk("held_first", first, 15);
    chk("held_gap", second - first, 16);
    repeat (20) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
